// File: rtl/cpu_pkg.sv
// cpu_pkg: shared write-back source encodings, MEM FSM states and word width
package cpu_pkg;
  localparam int WORD_W = 32;
  localparam logic [1:0] WB_SRC_ALU = 2'b00;
  localparam logic [1:0] WB_SRC_MEM = 2'b01;
  localparam logic [1:0] WB_SRC_JAL = 2'b10;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} mem_state_t;
endpackage

// File: rtl/cpu_mem_wbreg.sv
// cpu_mem_wbreg: MEM/WB pipeline register with sync reset and bubble insert
import cpu_pkg::*;
module cpu_mem_wbreg (
  input  logic              clk,
  input  logic              rst,
  input  logic              bubble,
  input  logic              c_rfw,
  input  logic [1:0]        c_wbsource,
  input  logic [WORD_W-1:0] alu_r,
  input  logic [WORD_W-1:0] dm_rdata,
  input  logic [4:0]        rf_waddr,
  input  logic [WORD_W-1:0] jalra,
  output logic              p_c_rfw,
  output logic [1:0]        p_c_wbsource,
  output logic [WORD_W-1:0] p_alu_r,
  output logic [WORD_W-1:0] p_dm_rdata,
  output logic [4:0]        p_rf_waddr,
  output logic [WORD_W-1:0] p_jalra
);
  // load the EX fields, or an all-zero bubble while the stage is stalled
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      p_c_rfw      <= 1'b0;
      p_c_wbsource <= WB_SRC_ALU;
      p_alu_r      <= '0;
      p_dm_rdata   <= '0;
      p_rf_waddr   <= '0;
      p_jalra      <= '0;
    end else begin
      p_c_rfw      <= c_rfw;
      p_c_wbsource <= c_wbsource;
      p_alu_r      <= alu_r;
      p_dm_rdata   <= dm_rdata;
      p_rf_waddr   <= rf_waddr;
      p_jalra      <= jalra;
    end
  end
endmodule

// File: rtl/cpu_mem.sv
// cpu_mem: memory-access stage with req/ack bus and stall; CPU_MEM_STFWD_EN enables WB->store-data forwarding
import cpu_pkg::*;
module cpu_mem (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_c_rfw,
  input  logic [1:0]        ex_c_wbsource,
  input  logic              ex_c_drw,
  input  logic [WORD_W-1:0] ex_alu_r,
  input  logic [WORD_W-1:0] ex_rfb,
  input  logic [4:0]        ex_rf_waddr,
  input  logic [WORD_W-1:0] ex_jalra,
  input  logic [4:0]        ex_rt,
  input  logic [WORD_W-1:0] wb_wdata,
  input  logic              wb_rfw,
  input  logic [4:0]        wb_waddr,
  input  logic [WORD_W-1:0] d_rdata,
  input  logic              d_ack,
  output logic              d_req,
  output logic              d_we,
  output logic [WORD_W-1:0] d_addr,
  output logic [WORD_W-1:0] d_wdata,
  output logic              stall,
  output logic              p_c_rfw,
  output logic [1:0]        p_c_wbsource,
  output logic [WORD_W-1:0] p_alu_r,
  output logic [WORD_W-1:0] p_dm_rdata,
  output logic [4:0]        p_rf_waddr,
  output logic [WORD_W-1:0] p_jalra
);
  mem_state_t state, state_n;
  logic [WORD_W-1:0] wdata_q, fwd_data, dm_rdata;
  logic access, ld_done;
`ifdef CPU_MEM_STFWD_EN
  assign fwd_data = (wb_rfw && wb_waddr == ex_rt && wb_waddr != 5'd0) ? wb_wdata : ex_rfb;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_wdata, wb_rfw, wb_waddr, ex_rt};
  assign fwd_data = ex_rfb;
`endif
  assign access   = ex_c_drw | (ex_c_wbsource == WB_SRC_MEM);
  assign d_req    = access;
  assign d_we     = ex_c_drw;
  assign d_addr   = {ex_alu_r[WORD_W-1:2], 2'b00};
  assign d_wdata  = (state == WAIT) ? wdata_q : fwd_data;
  assign stall    = access & ~d_ack;
  assign ld_done  = (ex_c_wbsource == WB_SRC_MEM) & ~ex_c_drw & d_ack;
  assign dm_rdata = ld_done ? d_rdata : '0;
  // state register; reset abandons any pending access
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
  end
  // next state: wait out an unacknowledged access
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? ((access & ~d_ack) ? WAIT : IDLE) : (d_ack ? IDLE : WAIT);
  end
  // capture store data when an access starts waiting so the bus value stays stable
  always_ff @(posedge clk) begin
    if (rst) wdata_q <= '0;
    else if (state == IDLE && access && !d_ack) wdata_q <= fwd_data;
  end
  cpu_mem_wbreg u_wbreg (
    .clk(clk), .rst(rst), .bubble(stall),
    .c_rfw(ex_c_rfw), .c_wbsource(ex_c_wbsource), .alu_r(ex_alu_r),
    .dm_rdata(dm_rdata), .rf_waddr(ex_rf_waddr), .jalra(ex_jalra),
    .p_c_rfw(p_c_rfw), .p_c_wbsource(p_c_wbsource), .p_alu_r(p_alu_r),
    .p_dm_rdata(p_dm_rdata), .p_rf_waddr(p_rf_waddr), .p_jalra(p_jalra)
  );
endmodule

// File: tb/tb_cpu_mem.sv
// tb_cpu_mem: directed self-checking bench for cpu_mem
module tb_cpu_mem;
  logic clk = 1'b0, rst;
  logic ex_c_rfw, ex_c_drw, wb_rfw, d_ack;
  logic [1:0] ex_c_wbsource;
  logic [31:0] ex_alu_r, ex_rfb, ex_jalra, wb_wdata, d_rdata;
  logic [4:0] ex_rf_waddr, ex_rt, wb_waddr;
  logic d_req, d_we, stall, p_c_rfw;
  logic [31:0] d_addr, d_wdata, p_alu_r, p_dm_rdata, p_jalra;
  logic [1:0] p_c_wbsource;
  logic [4:0] p_rf_waddr;
  int n_cmp = 0, n_err = 0;

  cpu_mem dut (
    .clk(clk), .rst(rst), .ex_c_rfw(ex_c_rfw), .ex_c_wbsource(ex_c_wbsource),
    .ex_c_drw(ex_c_drw), .ex_alu_r(ex_alu_r), .ex_rfb(ex_rfb),
    .ex_rf_waddr(ex_rf_waddr), .ex_jalra(ex_jalra), .ex_rt(ex_rt),
    .wb_wdata(wb_wdata), .wb_rfw(wb_rfw), .wb_waddr(wb_waddr),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .stall(stall), .p_c_rfw(p_c_rfw),
    .p_c_wbsource(p_c_wbsource), .p_alu_r(p_alu_r), .p_dm_rdata(p_dm_rdata),
    .p_rf_waddr(p_rf_waddr), .p_jalra(p_jalra)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ex();
    ex_c_rfw = 0; ex_c_wbsource = 2'b00; ex_c_drw = 0; ex_alu_r = 0; ex_rfb = 0;
    ex_rf_waddr = 0; ex_jalra = 0; ex_rt = 0; d_ack = 0; d_rdata = 0;
    wb_rfw = 0; wb_waddr = 0; wb_wdata = 0;
  endtask

  initial begin
    rst = 1; clr_ex();
    tick(); tick();
    rst = 0; #1;
    chk("rst_p_alu_r", p_alu_r, 32'h0);
    chk("rst_p_c_rfw", {31'b0, p_c_rfw}, 32'h0);
    chk("rst_p_dm_rdata", p_dm_rdata, 32'h0);
    chk("rst_d_req", {31'b0, d_req}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    // ALU op
    ex_c_rfw = 1; ex_alu_r = 32'h1234; ex_rf_waddr = 5'd3; ex_jalra = 32'h40; #1;
    chk("alu_d_req", {31'b0, d_req}, 32'h0);
    chk("alu_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("alu_p_alu_r", p_alu_r, 32'h1234);
    chk("alu_p_c_rfw", {31'b0, p_c_rfw}, 32'h1);
    chk("alu_p_rf_waddr", {27'b0, p_rf_waddr}, 32'h3);
    chk("alu_p_jalra", p_jalra, 32'h40);
    chk("alu_p_dm_rdata", p_dm_rdata, 32'h0);
    // zero-wait load
    ex_c_wbsource = 2'b01; ex_alu_r = 32'h103; ex_rf_waddr = 5'd4;
    d_ack = 1; d_rdata = 32'hDEADBEEF; #1;
    chk("ld_d_addr", d_addr, 32'h100);
    chk("ld_d_req", {31'b0, d_req}, 32'h1);
    chk("ld_d_we", {31'b0, d_we}, 32'h0);
    chk("ld_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("ld_p_dm_rdata", p_dm_rdata, 32'hDEADBEEF);
    chk("ld_p_wbsource", {30'b0, p_c_wbsource}, 32'h1);
    chk("ld_p_alu_r", p_alu_r, 32'h103);
    // two-wait store
    clr_ex();
    ex_c_drw = 1; ex_rfb = 32'hA5A5A5A5; ex_alu_r = 32'h200; ex_rf_waddr = 5'd9; #1;
    chk("st_stall0", {31'b0, stall}, 32'h1);
    chk("st_d_we", {31'b0, d_we}, 32'h1);
    chk("st_d_wdata0", d_wdata, 32'hA5A5A5A5);
    tick();
    chk("st_bubble_alu_r", p_alu_r, 32'h0);
    chk("st_bubble_rf_waddr", {27'b0, p_rf_waddr}, 32'h0);
    ex_rfb = 32'h11111111; #1;
    chk("st_d_wdata_held", d_wdata, 32'hA5A5A5A5);
    chk("st_stall1", {31'b0, stall}, 32'h1);
    chk("st_state_wait", {31'b0, dut.state}, 32'h1);
    tick();
    chk("st_bubble2_alu_r", p_alu_r, 32'h0);
    d_ack = 1; #1;
    chk("st_ack_stall", {31'b0, stall}, 32'h0);
    chk("st_ack_d_wdata", d_wdata, 32'hA5A5A5A5);
    tick();
    chk("st_p_alu_r", p_alu_r, 32'h200);
    chk("st_p_dm_rdata", p_dm_rdata, 32'h0);
    chk("st_state_idle", {31'b0, dut.state}, 32'h0);
    // back-to-back store presented right after the acknowledge
    ex_rfb = 32'h22222222; ex_alu_r = 32'h204; #1;
    chk("b2b_d_req", {31'b0, d_req}, 32'h1);
    chk("b2b_d_wdata", d_wdata, 32'h22222222);
    tick();
    chk("b2b_p_alu_r", p_alu_r, 32'h204);
    // ack with no access is ignored
    clr_ex(); d_ack = 1; d_rdata = 32'hFFFF; ex_alu_r = 32'h8; #1;
    chk("noacc_d_req", {31'b0, d_req}, 32'h0);
    chk("noacc_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("noacc_p_dm_rdata", p_dm_rdata, 32'h0);
    // load+store treated as store
    ex_c_drw = 1; ex_c_wbsource = 2'b01; d_rdata = 32'h55; #1;
    chk("ldst_d_we", {31'b0, d_we}, 32'h1);
    tick();
    chk("ldst_p_dm_rdata", p_dm_rdata, 32'h0);
    // store-data forwarding from write-back
    clr_ex();
    ex_c_drw = 1; ex_rt = 5'd5; ex_rfb = 32'h99; wb_rfw = 1; wb_waddr = 5'd5; wb_wdata = 32'h7; d_ack = 1; #1;
`ifdef CPU_MEM_STFWD_EN
    chk("fwd_match", d_wdata, 32'h7);
`else
    chk("fwd_match", d_wdata, 32'h99);
`endif
    ex_rt = 5'd0; wb_waddr = 5'd0; #1;
    chk("fwd_r0", d_wdata, 32'h99);
    tick();
    // reset while waiting
    clr_ex();
    ex_c_rfw = 1; ex_c_wbsource = 2'b01; ex_alu_r = 32'h300; ex_rf_waddr = 5'd6; ex_jalra = 32'h44;
    tick();
    chk("rw_state_wait", {31'b0, dut.state}, 32'h1);
    rst = 1;
    tick();
    chk("rw_state_idle", {31'b0, dut.state}, 32'h0);
    chk("rw_p_alu_r", p_alu_r, 32'h0);
    chk("rw_p_rf_waddr", {27'b0, p_rf_waddr}, 32'h0);
    chk("rw_p_jalra", p_jalra, 32'h0);
    chk("rw_p_c_rfw", {31'b0, p_c_rfw}, 32'h0);
    clr_ex(); rst = 0; #1;
    chk("rw_d_req", {31'b0, d_req}, 32'h0);
    chk("rw_stall", {31'b0, stall}, 32'h0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cpu_mem.md
# cpu_mem

Memory-access pipeline stage, directly downstream of the execute stage. It takes the EX/MEM pipeline register contents, performs word loads and stores over a request/acknowledge data bus, and stalls the pipeline while an access is outstanding. It drives the MEM/WB pipeline register consumed by write-back.

## Interface
Parameters:
- none; data and address widths are fixed at 32 bits.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- ex_c_rfw  in  1  register-file write enable from EX.
- ex_c_wbsource  in  2  write-back source: 00 = ALU, 01 = data memory, 10 = jalra.
- ex_c_drw  in  1  store enable.
- ex_alu_r  in  32  ALU result; this is the memory address for loads and stores.
- ex_rfb  in  32  store data, already forwarded in EX.
- ex_rf_waddr  in  5  destination register.
- ex_jalra  in  32  link address.
- ex_rt  in  5  rt of the instruction; used for store-data forwarding.
- wb_wdata  in  32  write-back data.
- wb_rfw  in  1  write-back enable.
- wb_waddr  in  5  write-back register address.
- d_rdata  in  32  bus read data; valid when d_ack = 1.
- d_ack  in  1  bus acknowledge.
- d_req  out  1  bus request.
- d_we  out  1  bus write.
- d_addr  out  32  bus address, word aligned.
- d_wdata  out  32  bus write data.
- stall  out  1  freezes PC, IF/ID and EX/MEM.
- p_c_rfw  out  1  MEM/WB: write enable.
- p_c_wbsource  out  2  MEM/WB: write-back source.
- p_alu_r  out  32  MEM/WB: ALU result.
- p_dm_rdata  out  32  MEM/WB: load data.
- p_rf_waddr  out  5  MEM/WB: destination register.
- p_jalra  out  32  MEM/WB: link address.

## Operation
Access qualification:
- access = ex_c_drw | (ex_c_wbsource == 01). An instruction that is both a load and a store is treated as a store.

Bus drive:
- d_addr = {ex_alu_r[31:2], 2'b00}; low address bits are ignored.
- d_we = ex_c_drw.
- d_req = access in both IDLE and WAIT.

FSM states:
- IDLE: if access & d_ack, the access completes this cycle (zero wait state); stay in IDLE. If access & !d_ack, latch the store data into wdata_q and go to WAIT.
- WAIT: hold d_req, d_addr and d_we. d_wdata comes from wdata_q. On d_ack, go to IDLE.

Store data:
- In IDLE, d_wdata = fwd_data, the forwarded store data (see Configuration).
- In WAIT, d_wdata = wdata_q, so the value cannot change while the bus is pending.

Stall and MEM/WB register:
- stall = access & !d_ack, combinational.
- While stall = 1, MEM/WB loads a bubble: p_c_rfw = 0, p_c_wbsource = 00, all other p_* fields = 0. EX/MEM is held by upstream.
- Otherwise MEM/WB loads the EX fields, with p_dm_rdata = d_rdata on a completed load and 0 for any other instruction.

## Timing
- Reset: state = IDLE, wdata_q = 0, and every p_* output = 0.
- d_req, d_we and stall follow ex_* with no registered delay.
- Reset during WAIT: state returns to IDLE on the next edge and the pending access is abandoned. Upstream has also reset, so access = 0 and d_req drops.
- Non-access instructions pass through with 1-cycle latency.
- A load or store acknowledged after n wait cycles costs n stall cycles.
- d_ack while access = 0 is ignored.
- Back-to-back accesses: on the acknowledge cycle the FSM returns to IDLE. The next instruction presents its request in the following cycle; no idle bus cycle is inserted beyond that.

## Configuration
- CPU_MEM_STFWD_EN defined: fwd_data = wb_wdata when wb_rfw & (wb_waddr == ex_rt) & (wb_waddr != 0); otherwise fwd_data = ex_rfb. This covers a load followed immediately by a store of the same register.
- CPU_MEM_STFWD_EN undefined: fwd_data = ex_rfb; the wb_* inputs are unused.

## Structure
- Shared package cpu_pkg holds the WB_SRC_ALU/WB_SRC_MEM/WB_SRC_JAL encodings (00/01/10), the MEM FSM state constants (IDLE, WAIT) and the 32-bit word width constant.
- One sub-module, cpu_mem_wbreg, is natural. It is the MEM/WB pipeline register with synchronous reset and bubble-insert input.
- The FSM, bus drive and forwarding mux stay in cpu_mem.

## Test plan
- ALU op: ex_c_rfw = 1, wbsource = 00, alu_r = 0x1234 -> next cycle p_alu_r = 0x1234, p_c_rfw = 1, d_req = 0, stall = 0.
- Zero-wait load: wbsource = 01, alu_r = 0x103, d_ack = 1 in the same cycle with d_rdata = 0xDEADBEEF -> d_addr = 0x100, stall = 0, next cycle p_dm_rdata = 0xDEADBEEF.
- Two-wait store: drw = 1, ex_rfb = 0xA5A5A5A5, d_ack after 2 cycles -> stall = 1 for 2 cycles, during which MEM/WB is a bubble. d_wdata stays 0xA5A5A5A5 even while ex_rfb changes.
- Forwarding with CPU_MEM_STFWD_EN defined: store with ex_rt = 5 while wb_rfw = 1, wb_waddr = 5, wb_wdata = 7 -> d_wdata = 7. With wb_waddr = 0 instead -> d_wdata = ex_rfb.
- Reset in WAIT: assert rst for one cycle mid-access -> all p_* = 0, state = IDLE, and d_req = 0 once ex_* are zero.
